display_timing_gen: RTL and testbench

Parametrised raster timing generator for the StarSoC display path. Derives a pixel-rate tick from the system clock and walks horizontal/vertical counters through active, front-porch, sync and back-porch regions. Drives pixel coordinates, hsync/vsync, video_on, line/frame strobes and a frame counter to the HDMI encoder and to game logic. Resolution, porches, sync polarity and clock divide are set by parameter; enable-controlled pause is supported.

---
 rtl/display_timing_gen.sv | 109 ++++++++++
 tb/tb_display_timing_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// display_timing_gen: pixel-tick divider plus raster counters producing
// coordinates, syncs, video_on, line/frame strobes and a frame counter.
module display_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 4,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               p_tick,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]      div_q, div_d;
  logic               p_tick_q, p_tick_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               wrap, h_wrap;

  // Registered outputs are derived from the next-state counters so they
  // switch on the same edge as x/y.
  always_comb begin
    wrap          = div_q == DIV_LAST;
    h_wrap        = p_tick_q && x_q == H_LAST;
    div_d         = enable ? (wrap ? '0 : div_q + DW'(1)) : div_q;
    p_tick_d      = enable && wrap;
    x_d           = p_tick_q ? (h_wrap ? '0 : x_q + XW'(1)) : x_q;
    y_d           = h_wrap ? (y_q == V_LAST ? '0 : y_q + YW'(1)) : y_q;
    hsync_d       = (x_d >= HS_BEG && x_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (y_d >= VS_BEG && y_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    video_on_d    = x_d < H_VIS && y_d < V_VIS;
    line_start_d  = p_tick_q && x_d == '0;
    frame_start_d = line_start_d && y_d == '0;
    frame_count_d = frame_count_q + FRAME_W'(frame_start_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: directed checks of a default 640x480 instance and a
// tiny CLK_DIV=1 instance, with hand-computed expectations.
module tb_display_timing_gen;
  logic clk = 1'b0;
  logic reset_a = 1'b1, en_a = 1'b1, reset_b = 1'b1, en_b = 1'b1;
  logic pt_a, hs_a, vs_a, vo_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [15:0] fc_a;
  logic pt_b, hs_b, vs_b, vo_b, ls_b, fs_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic [1:0] fc_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  display_timing_gen dut_a (
    .clk(clk), .reset(reset_a), .enable(en_a), .p_tick(pt_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );

  display_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(1),
    .XW(4), .YW(3), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .enable(en_b), .p_tick(pt_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input int tx, input int ty);
    int n = 0;
    while (!(x_a == 10'(tx) && y_a == 10'(ty)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_xy", 32'(x_a == 10'(tx) && y_a == 10'(ty)), 1);
  endtask

  initial begin
    int mx, my, mfc, nlow, ex, ey;
    #1 reset_a = 1'b0;
    reset_b = 1'b0;
    #1;
    chk("rst_x", x_a, 799);
    chk("rst_y", y_a, 524);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_vo", vo_a, 0);
    chk("rst_pt", pt_a, 0);
    chk("rst_ls", ls_a, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_fc", fc_a, 0);
    chk("rst_b_x", x_b, 11);
    chk("rst_b_y", y_b, 6);
    chk("rst_b_hs", hs_b, 0);
    // small raster: one pixel per clk, 12x7, 2-bit frame counter
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk("b_pt_first", pt_b, 1);
    chk("b_x_first", x_b, 11);
    mx = 0; my = 0; mfc = 1;
    for (int k = 0; k <= 336; k++) begin
      @(negedge clk);
      chk("b_x", x_b, 32'(mx));
      chk("b_y", y_b, 32'(my));
      chk("b_pt", pt_b, 1);
      chk("b_hs", hs_b, 32'(mx == 9 || mx == 10));
      chk("b_vs", vs_b, 32'(my != 5));
      chk("b_vo", vo_b, 32'(mx < 8 && my < 4));
      chk("b_ls", ls_b, 32'(mx == 0));
      chk("b_fs", fs_b, 32'(mx == 0 && my == 0));
      chk("b_fc", fc_b, 32'(mfc));
      mx++;
      if (mx == 12) begin
        mx = 0;
        my = (my == 6) ? 0 : my + 1;
      end
      if (mx == 0 && my == 0) mfc = (mfc + 1) % 4;
    end
    // default raster from reset release
    @(negedge clk);
    reset_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_pt_lo", pt_a, 0);
      chk("a_x_hold", x_a, 799);
    end
    @(negedge clk);
    chk("a_pt_first", pt_a, 1);
    chk("a_x_pre", x_a, 799);
    @(negedge clk);
    chk("a_x0", x_a, 0);
    chk("a_y0", y_a, 0);
    chk("a_vo0", vo_a, 1);
    chk("a_ls0", ls_a, 1);
    chk("a_fs0", fs_a, 1);
    chk("a_fc0", fc_a, 1);
    chk("a_pt0", pt_a, 0);
    nlow = 0;
    for (int px = 1; px <= 800; px++) begin
      @(negedge clk);
      chk("a_ls_1clk", ls_a, 0);
      chk("a_fs_1clk", fs_a, 0);
      repeat (2) @(negedge clk);
      chk("a_pt_period", pt_a, 1);
      @(negedge clk);
      ex = px % 800;
      ey = px / 800;
      chk("a_x", x_a, 32'(ex));
      chk("a_y", y_a, 32'(ey));
      chk("a_hs", hs_a, 32'(!(ex >= 656 && ex < 752)));
      chk("a_vo", vo_a, 32'(ex < 640));
      chk("a_ls", ls_a, 32'(ex == 0));
      chk("a_fs", fs_a, 0);
      if (hs_a === 1'b0) nlow++;
    end
    chk("a_hs_width", 32'(nlow), 96);
    chk("a_fc_line", fc_a, 1);
    // pause with the divider mid-count
    wait_xy(100, 5);
    en_a = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      chk("p_x", x_a, 100);
      chk("p_y", y_a, 5);
      chk("p_pt", pt_a, 0);
      chk("p_ls", ls_a, 0);
      chk("p_vo", vo_a, 1);
      chk("p_hs", hs_a, 1);
      chk("p_vs", vs_a, 1);
    end
    en_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("r_pt_lo", pt_a, 0);
    @(negedge clk);
    chk("r_pt_hi", pt_a, 1);
    chk("r_x_hold", x_a, 100);
    @(negedge clk);
    chk("r_x", x_a, 101);
    chk("r_y", y_a, 5);
    // asynchronous reset between clock edges
    wait_xy(300, 5);
    #2 reset_a = 1'b0;
    #1;
    chk("ar_x", x_a, 799);
    chk("ar_y", y_a, 524);
    chk("ar_hs", hs_a, 1);
    chk("ar_vs", vs_a, 1);
    chk("ar_vo", vo_a, 0);
    chk("ar_fc", fc_a, 0);
    chk("ar_pt", pt_a, 0);
    @(negedge clk);
    reset_a = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_pt_first", pt_a, 1);
    @(negedge clk);
    chk("ar_x0", x_a, 0);
    chk("ar_y0", y_a, 0);
    chk("ar_fs", fs_a, 1);
    chk("ar_fc1", fc_a, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
